// File: rtl/morph_3x3_stream.sv
`default_nettype none
// ============================================================================
// morph_3x3_stream : streaming 3x3 grey-level erosion/dilation, cross/square
// Revision: 1.0
// ============================================================================
module morph_3x3_stream #(
    parameter int DATA_W = 24,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              sof_in,
    input  logic [DATA_W-1:0] din,
    input  logic              mode,
    input  logic              shape,
    output logic              valid_out,
    output logic              sof_out,
    output logic              eof_out,
    output logic [DATA_W-1:0] dout
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [RW-1:0]     row_q, row_d, cur_row;
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];
    logic              cfg_mode_q, cfg_shape_q;
    logic              emit_q, fsof_q, feof_q;
    logic              valid_out_q, sof_out_q, eof_out_q;
    logic [DATA_W-1:0] dout_q, red_d;

    // A qualified start-of-frame forces the pixel position to (0,0).
    always_comb begin
        cur_col = sof_in ? '0 : col_q;
        cur_row = sof_in ? '0 : row_q;
        col_d   = cur_col + 1'b1;
        row_d   = cur_row;
        if (cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb0_q[cur_col] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            cfg_mode_q  <= 1'b0;
            cfg_shape_q <= 1'b0;
            emit_q      <= 1'b0;
            fsof_q      <= 1'b0;
            feof_q      <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            emit_q <= 1'b0;
            if (valid_in) begin
                col_q <= col_d;
                row_q <= row_d;
                if (sof_in) begin
                    cfg_mode_q  <= mode;
                    cfg_shape_q <= shape;
                end
                // Row 0 is the oldest line, column 2 the newest pixel.
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_q[cur_col];
                win_q[1][2] <= lb0_q[cur_col];
                win_q[2][2] <= din;
                emit_q <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
                fsof_q <= (cur_row == RW'(2)) && (cur_col == CW'(2));
                feof_q <= (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
            end
        end
    end

    // Cross keeps only the middle row and middle column of the window.
    always_comb begin
        red_d = win_q[1][1];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (cfg_shape_q || (r == 1) || (c == 1)) begin
                    if (cfg_mode_q) begin
                        if (win_q[r][c] > red_d) red_d = win_q[r][c];
                    end else begin
                        if (win_q[r][c] < red_d) red_d = win_q[r][c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_q <= 1'b0;
            sof_out_q   <= 1'b0;
            eof_out_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            valid_out_q <= emit_q;
            sof_out_q   <= emit_q & fsof_q;
            eof_out_q   <= emit_q & feof_q;
            if (emit_q) dout_q <= red_d;
        end
    end

    assign valid_out = valid_out_q;
    assign sof_out   = sof_out_q;
    assign eof_out   = eof_out_q;
    assign dout      = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_morph_3x3_stream.sv
`default_nettype none
// ============================================================================
// tb_morph_3x3_stream : randomized and directed bench against a frame model
// Revision: 1.0
// ============================================================================
module tb_morph_3x3_stream;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic       sof_in = 1'b0;
    logic [7:0] din = '0;
    logic       mode = 1'b0;
    logic       shape = 1'b0;
    logic       valid_out, sof_out, eof_out;
    logic [7:0] dout;

    morph_3x3_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in),
        .din(din), .mode(mode), .shape(shape), .valid_out(valid_out),
        .sof_out(sof_out), .eof_out(eof_out), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] val;
        logic       s;
        logic       e;
    } exp_t;

    exp_t       q[$];
    logic [7:0] img [H][W];
    int         ncmp = 0;
    int         nfail = 0;
    int         k = 0;
    int         mrow = 0;
    int         mcol = 0;
    logic       cm = 1'b0;
    logic       cs = 1'b0;
    logic [7:0] last = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, k);
        end
    endtask

    // Reference: min/max over the neighbourhood of output centre (r-1,c-1).
    function automatic logic [7:0] calc(input int r, input int c);
        logic [7:0] v;
        v = img[r-1][c-1];
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (cs || dr == 0 || dc == 0) begin
                    if (cm && img[r-1+dr][c-1+dc] > v) v = img[r-1+dr][c-1+dc];
                    if (!cm && img[r-1+dr][c-1+dc] < v) v = img[r-1+dr][c-1+dc];
                end
            end
        end
        return v;
    endfunction

    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic m, input logic sh);
        int   r, c;
        exp_t e;
        valid_in = v; sof_in = s; din = d; mode = m; shape = sh;
        @(posedge clk);
        k++;
        #1;
        if (q.size() > 0 && q[0].due == k) begin
            e = q.pop_front();
            chk("valid_out", 32'(valid_out), 1);
            chk("dout", 32'(dout), 32'(e.val));
            chk("sof_out", 32'(sof_out), 32'(e.s));
            chk("eof_out", 32'(eof_out), 32'(e.e));
            last = e.val;
        end else begin
            chk("valid_out_idle", 32'(valid_out), 0);
            chk("sof_out_idle", 32'(sof_out), 0);
            chk("eof_out_idle", 32'(eof_out), 0);
            chk("dout_hold", 32'(dout), 32'(last));
        end
        if (v) begin
            if (s) begin
                r = 0; c = 0; cm = m; cs = sh;
            end else begin
                r = mrow; c = mcol;
            end
            img[r][c] = d;
            if (r >= 2 && c >= 2) begin
                e.due = k + 1;
                e.val = calc(r, c);
                e.s   = (r == 2 && c == 2);
                e.e   = (r == H-1 && c == W-1);
                q.push_back(e);
            end
            mcol = (c == W-1) ? 0 : c + 1;
            mrow = (c == W-1) ? ((r == H-1) ? 0 : r + 1) : r;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // kind: 0 ramp 4r+c, 1 all 255 with a 0 at (1,1), 2 random.
    // gap: 0 none, 1 alternate, 2 random. flip: randomize mode/shape per pixel.
    task automatic frame(input int kind, input int gap, input logic m0, input logic s0,
                         input int npix, input int flip, input int usesof);
        logic [7:0] d;
        logic       m, sh;
        for (int i = 0; i < npix; i++) begin
            if (kind == 0)      d = 8'(4 * (i / W) + (i % W));
            else if (kind == 1) d = (i == W + 1) ? 8'd0 : 8'd255;
            else                d = 8'($urandom);
            m  = (flip != 0 && i != 0) ? 1'($urandom) : m0;
            sh = (flip != 0 && i != 0) ? 1'($urandom) : s0;
            step(1'b1, (i == 0) && (usesof != 0), d, m, sh);
            if (gap == 1) idle();
            if (gap == 2) while ($urandom_range(0, 3) == 0) idle();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) idle();
        chk("drain_empty", 32'(q.size()), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_sof_out", 32'(sof_out), 0);
        chk("rst_eof_out", 32'(eof_out), 0);
        chk("rst_dout", 32'(dout), 0);
        rst_n = 1'b1;

        frame(0, 0, 1'b0, 1'b0, 16, 0, 1);   // erode cross: 1 2 5 6
        drain();
        frame(0, 0, 1'b1, 1'b1, 16, 0, 1);   // dilate square: 10 11 14 15
        drain();
        frame(0, 0, 1'b0, 1'b1, 16, 0, 1);   // erode square: 0 1 4 5
        drain();
        frame(0, 1, 1'b0, 1'b0, 16, 1, 1);   // gapped, config churn mid-frame
        drain();
        frame(1, 0, 1'b0, 1'b0, 16, 0, 1);
        drain();
        frame(1, 0, 1'b0, 1'b1, 16, 0, 1);
        drain();
        frame(0, 0, 1'b1, 1'b0, 6, 0, 1);    // abandoned after 6 pixels
        frame(0, 0, 1'b1, 1'b0, 16, 0, 1);
        drain();

        for (int f = 0; f < 24; f++) begin
            frame(2, 2, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16,
                  1, ($urandom_range(0, 4) == 0) ? 0 : 1);
        end
        drain();

        // Reset while one output is visible and another is in stage 2.
        frame(0, 0, 1'b1, 1'b1, 12, 0, 1);
        chk("pre_rst_valid", 32'(valid_out), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_out", 32'(valid_out), 0);
        chk("async_rst_dout", 32'(dout), 0);
        chk("async_rst_sof_out", 32'(sof_out), 0);
        q.delete();
        last = '0; mrow = 0; mcol = 0; cm = 1'b0; cs = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        frame(0, 0, 1'b1, 1'b1, 16, 0, 0);   // no sof: reset config erode/cross
        drain();
        frame(0, 2, 1'b1, 1'b1, 16, 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
